fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx_if.sv | 21 ++
 rtl/fifo_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port between the synchronous FIFO and its UART drain stage.
// master: the drain (drives re); slave: the FIFO (drives empty, rd_data).
interface fifo_uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  re;
   logic                  empty;
   logic [DATA_WIDTH-1:0] rd_data;

   modport master (
      output re,
      input  empty,
      input  rd_data
   );

   modport slave (
      input  re,
      output empty,
      output rd_data
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous FIFO and sends UART frames.
// Ports: clk, rst (async, active-high), en (gates new pops), fifo (master
// read port: re/empty/rd_data), tx (registered line, idle high), busy.
// Optional: define FIFO_UART_TX_PARITY_EN to add an even parity bit.
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   fifo_uart_tx_if.master fifo,
   output logic           tx,
   output logic           busy
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CW = $clog2(DATA_WIDTH) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_STOP
   } state_t;
`endif

   state_t                state, state_n;
   logic                  re_q, re_n;
   logic                  tx_q, tx_n;
   logic [BW-1:0]         baud, baud_n;
   logic [CW-1:0]         bit_cnt, bit_n;
   logic [DATA_WIDTH-1:0] shift, shift_n;
   logic                  baud_last;
   logic                  pop_ok;
`ifdef FIFO_UART_TX_PARITY_EN
   logic                  par_q, par_n;
`endif

   assign fifo.re   = re_q;
   assign tx        = tx_q;
   assign busy      = (state != S_IDLE);
   assign baud_last = (baud == BAUD_LAST);
   assign pop_ok    = en && !fifo.empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         re_q    <= 1'b0;
         tx_q    <= 1'b1;
         baud    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         re_q    <= re_n;
         tx_q    <= tx_n;
         baud    <= baud_n;
         bit_cnt <= bit_n;
         shift   <= shift_n;
`ifdef FIFO_UART_TX_PARITY_EN
         par_q   <= par_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      re_n    = 1'b0;
      tx_n    = tx_q;
      baud_n  = baud;
      bit_n   = bit_cnt;
      shift_n = shift;
`ifdef FIFO_UART_TX_PARITY_EN
      par_n   = par_q;
`endif
      unique case (state)
         S_IDLE: begin
            tx_n   = 1'b1;
            baud_n = '0;
            if (pop_ok) begin
               re_n    = 1'b1;
               state_n = S_REQ;
            end
         end
         // re is high for this one cycle; FIFO data lands next cycle
         S_REQ: begin
            state_n = S_WAIT;
         end
         S_WAIT: begin
            shift_n = fifo.rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
            par_n   = ^fifo.rd_data;
`endif
            tx_n    = 1'b0;
            baud_n  = '0;
            state_n = S_START;
         end
         S_START: begin
            if (baud_last) begin
               tx_n    = shift[0];
               bit_n   = '0;
               baud_n  = '0;
               state_n = S_DATA;
            end else begin
               baud_n = baud + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_n = '0;
               if (bit_cnt == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  tx_n    = par_q;
                  state_n = S_PARITY;
`else
                  tx_n    = 1'b1;
                  state_n = S_STOP;
`endif
               end else begin
                  // next bit is the new LSB after the shift
                  shift_n = shift >> 1;
                  tx_n    = shift_n[0];
                  bit_n   = bit_cnt + 1'b1;
               end
            end else begin
               baud_n = baud + 1'b1;
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_last) begin
               tx_n    = 1'b1;
               baud_n  = '0;
               state_n = S_STOP;
            end else begin
               baud_n = baud + 1'b1;
            end
         end
`endif
         // last stop cycle is the only mid-stream pop decision point
         S_STOP: begin
            if (baud_last) begin
               baud_n = '0;
               if (pop_ok) begin
                  re_n    = 1'b1;
                  state_n = S_REQ;
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               baud_n = baud + 1'b1;
            end
         end
         default: begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: queue-based FIFO, frame-level line model,
// per-cycle compare plus directed literal checks.
module tb_fifo_uart_tx;

   localparam int DW = 8;
   localparam int C  = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NB    = DW + 3;
   localparam int FRAME = 44;
`else
   localparam int NB    = DW + 2;
   localparam int FRAME = 40;
`endif
   localparam int TEND = 1 + NB * C;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic tx;
   logic busy;

   fifo_uart_tx_if #(.DATA_WIDTH(DW)) fif ();

   fifo_uart_tx #(
      .DATA_WIDTH  (DW),
      .CLKS_PER_BIT(C)
   ) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .fifo(fif),
      .tx  (tx),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_on = 1'b0;
   logic txh [0:4095];
   int rq [$];

   // FIFO: write lands on the next edge; read data valid after the re edge
   logic [DW-1:0] pq [$];
   logic [DW-1:0] fq [$];
   always @(posedge clk) begin
      if (fif.re && fq.size() > 0)
         fif.rd_data <= fq.pop_front();
      while (pq.size() > 0)
         fq.push_back(pq.pop_front());
      fif.empty <= (fq.size() == 0);
   end

   // line model: t=0 re cycle, t=1 data wait, then NB bits of C cycles
   bit            m_act = 1'b0;
   int            m_t   = 0;
   logic [DW-1:0] m_byte = '0;
   logic [DW-1:0] mq [$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_act = 1'b0;
         m_t   = 0;
      end else if (m_act && m_t < TEND) begin
         if (m_t == 0 && mq.size() > 0)
            m_byte = mq.pop_front();
         m_t++;
      end else if (en && !fif.empty) begin
         m_act = 1'b1;
         m_t   = 0;
      end else begin
         m_act = 1'b0;
      end
   end

   function automatic logic exp_tx();
      int k;
      if (!m_act || m_t < 2) return 1'b1;
      k = (m_t - 2) / C;
      if (k == 0) return 1'b0;
      if (k <= DW) return m_byte[k-1];
`ifdef FIFO_UART_TX_PARITY_EN
      if (k == DW + 1) return ^m_byte;
`endif
      return 1'b1;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      txh[cyc] = tx;
      if (fif.re === 1'b1) rq.push_back(cyc);
      if (chk_on) begin
         chk("re", fif.re, (m_act && m_t == 0) ? 1 : 0);
         chk("tx", tx, exp_tx());
         chk("busy", busy, m_act);
         chk("re_empty", fif.re & fif.empty, 0);
      end
   endtask

   task automatic push(input logic [DW-1:0] b);
      pq.push_back(b);
      mq.push_back(b);
   endtask

   task automatic wait_re(input int lim, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (fif.re !== 1'b1 && n < lim);
      chk("wait_re", fif.re, 1);
   endtask

   task automatic wait_idle(input int lim, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (busy !== 1'b0 && n < lim);
      chk("wait_idle", busy, 0);
   endtask

   logic fr_a5 [9] = '{0, 1, 0, 1, 0, 0, 1, 0, 1};
   logic fr_69 [9] = '{0, 1, 0, 0, 1, 0, 1, 1, 0};

   initial begin
      int n, n0, rp;
      repeat (3) tick();
      #2 rst = 1'b0;
      chk_on = 1'b1;
      repeat (2) tick();

      // async reset kills a pending re without an edge
      push(8'hA5);
      repeat (2) tick();
      en = 1'b1;
      tick();
      chk("pre_rst_re", fif.re, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_re", fif.re, 0);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      tick();
      n0 = rq.size();
      #2 rst = 1'b0;
      wait_re(3, n);
      chk("re_first_edge", n, 1);
      rp = cyc;

      // single 0xA5 frame
      wait_idle(200, n);
      chk("a5_len", n - 2, FRAME);
      chk("a5_wait_tx", txh[rp+1], 1);
      for (int k = 0; k < 9; k++)
         chk("a5_bit", txh[rp+2+C*k+1], fr_a5[k]);
      chk("a5_stop", txh[rp+2+C*(NB-1)+1], 1);
      chk("a5_pulses", rq.size() - n0, 1);
      chk("a5_empty", fif.empty, 1);

      // back-to-back 0x3C, 0xFF
      n0 = rq.size();
      push(8'h3C);
      push(8'hFF);
      wait_re(5, n);
      wait_idle(300, n);
      chk("b2b_pulses", rq.size() - n0, 2);
      chk("b2b_gap", rq[n0+1] - rq[n0], FRAME + 2);

      // empty FIFO with en high
      n0 = rq.size();
      repeat (100) tick();
      chk("idle_no_re", rq.size() - n0, 0);

      // en dropped mid-frame
      n0 = rq.size();
      push(8'h11);
      push(8'h22);
      wait_re(5, n);
      repeat (20) tick();
      en = 1'b0;
      wait_idle(200, n);
      repeat (10) tick();
      chk("en_drop_pulses", rq.size() - n0, 1);
      en = 1'b1;
      wait_re(5, n);
      chk("en_back_lat", n, 1);
      wait_idle(200, n);
      chk("en_back_pulses", rq.size() - n0, 2);

      // reset during data bit 3 of 0x52
      push(8'h52);
      push(8'h69);
      wait_re(5, n);
      repeat (19) tick();
      chk("bit3_tx", tx, 0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_busy", busy, 0);
      tick();
      #2 rst = 1'b0;
      wait_re(3, n);
      chk("post_rst_lat", n, 1);
      rp = cyc;
      wait_idle(200, n);
      chk("r69_len", n - 2, FRAME);
      for (int k = 0; k < 9; k++)
         chk("r69_bit", txh[rp+2+C*k+1], fr_69[k]);

`ifdef FIFO_UART_TX_PARITY_EN
      push(8'h07);
      wait_re(5, n);
      rp = cyc;
      wait_idle(200, n);
      chk("p07_len", n - 2, 44);
      chk("p07_par", txh[rp+2+C*9+1], 1);
      push(8'h03);
      wait_re(5, n);
      rp = cyc;
      wait_idle(200, n);
      chk("p03_par", txh[rp+2+C*9+1], 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
